// File: rtl/vga_pkg.sv
// Shared constants and types for the bouncing-squares VGA design.
package vga_pkg;

  localparam int H_SIZE  = 640;
  localparam int V_SIZE  = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int SQ_SIZE = 100;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } sched_state_e;

  // True when j is the final partner visited for row i (the engine commits i).
  function automatic logic is_last_pair(input int i, input int j, input int n);
    return (j == n - 1) || ((i == n - 1) && (j == n - 2));
  endfunction

endpackage

// File: rtl/vga_frame_timer.sv
// Decodes frame boundaries from the VGA counters and divides frames down to
// the update period, producing a start_ok pulse on qualifying frames.
module vga_frame_timer
  import vga_pkg::*;
#(
  parameter int FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       enable,
  output logic       start_ok,
  output logic       active_start
);

  logic       new_frame;
  logic [3:0] frame_cnt_q, frame_cnt_d;

  assign new_frame    = (sy == 10'(V_SIZE)) && (sx == '0);
  assign active_start = (sy == '0) && (sx == '0);
  assign start_ok     = new_frame && enable && (frame_cnt_q == '0);

  // Paused frames do not count towards the update period.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (new_frame && enable) begin
      frame_cnt_d = (frame_cnt_q == 4'(FRAMES - 1)) ? 4'd0 : frame_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

endmodule

// File: rtl/vga_square_update_sched.sv
// Walks every ordered square pair once per update frame, feeding a single
// shared position/collision engine through a valid/ready/done handshake.
module vga_square_update_sched
  import vga_pkg::*;
#(
  parameter int N_SQ   = 4,
  parameter int FRAMES = 1,
  localparam int IW    = $clog2(N_SQ)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    sx,
  input  logic [9:0]    sy,
  input  logic          enable,
  output logic          upd_valid,
  output logic [IW-1:0] upd_idx,
  output logic [IW-1:0] osq_idx,
  output logic          upd_last,
  input  logic          upd_ready,
  input  logic          upd_done,
  output logic          busy,
  output logic          frame_tick,
  output logic          overrun
);

  localparam int CW = IW + 1;

  sched_state_e  state_q;
  logic [IW-1:0] i_q, j_q;
  logic          last_q, valid_q, busy_q, tick_q, overrun_q;
  logic          start_ok, active_start;
  logic [CW-1:0] j_inc, i_d, j_d;
  logic          last_d;

  vga_frame_timer #(.FRAMES(FRAMES)) u_frame_timer (
    .clk         (clk),
    .rst         (rst),
    .sx          (sx),
    .sy          (sy),
    .enable      (enable),
    .start_ok    (start_ok),
    .active_start(active_start)
  );

  // Next pair skips the diagonal; the extra index bit exposes the column wrap.
  always_comb begin
    j_inc = {1'b0, j_q} + CW'(1);
    if (j_inc == {1'b0, i_q}) j_inc = j_inc + CW'(1);
    i_d = {1'b0, i_q};
    j_d = j_inc;
    if (j_inc > CW'(N_SQ - 1)) begin
      i_d = {1'b0, i_q} + CW'(1);
      j_d = (i_d == '0) ? CW'(1) : '0;
    end
    last_d = is_last_pair(int'(i_d), int'(j_d), N_SQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (active_start && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= ISSUE;
            i_q     <= '0;
            j_q     <= IW'(1);
            last_q  <= is_last_pair(0, 1, N_SQ);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            tick_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (upd_ready) begin
            valid_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (upd_done) state_q <= NEXT;
        end
        NEXT: begin
          if ((i_q == IW'(N_SQ - 1)) && last_q) begin
            state_q <= DONE;
          end else begin
            i_q     <= i_d[IW-1:0];
            j_q     <= j_d[IW-1:0];
            last_q  <= last_d;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign upd_valid  = valid_q;
  assign upd_idx    = i_q;
  assign osq_idx    = j_q;
  assign upd_last   = last_q;
  assign busy       = busy_q;
  assign frame_tick = tick_q;
  assign overrun    = overrun_q;

endmodule
